// File: rtl/mem_port_arbiter.sv
// Round-robin N-port arbiter in front of a single shared backing-memory port.
// Optional coherence snoop outputs are enabled by defining ARB_SNOOP_INVALIDATE_EN.
`timescale 1ns/1ps
module mem_port_arbiter #(
  parameter  int NUM_PORTS  = 2,
  parameter  int ADDR_WIDTH = 16,
  parameter  int DATA_WIDTH = 8,
  parameter  int LINE_WIDTH = 16,
  localparam int REQ_W      = 1 + DATA_WIDTH + ADDR_WIDTH,
  localparam int PW         = $clog2(NUM_PORTS)
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic [NUM_PORTS*REQ_W-1:0]      cache_request,
  input  logic [NUM_PORTS-1:0]            cache_request_ready,
  output logic [NUM_PORTS*LINE_WIDTH-1:0] cache_response,
  output logic [NUM_PORTS-1:0]            cache_response_ready,
  output logic [REQ_W-1:0]                memory_request,
  output logic                            memory_request_ready,
  input  logic [LINE_WIDTH-1:0]           memory_response,
  input  logic                            memory_response_ready,
  output logic [PW-1:0]                   grant_port
`ifdef ARB_SNOOP_INVALIDATE_EN
  ,
  output logic [NUM_PORTS-1:0]            snoop_invalidate,
  output logic [ADDR_WIDTH-1:0]           snoop_address
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RETURN} state_e;

  state_e                  state_q;
  logic [PW-1:0]           rr_q, rr_d;
  logic [PW-1:0]           winner_q, grant_q;
  logic                    latched_q, withdrawn_q, mem_valid_q;
  logic [REQ_W-1:0]        req_q;
  logic [LINE_WIDTH-1:0]   line_q;
  logic [NUM_PORTS-1:0]    resp_valid_q;

  logic                    pick_found;
  logic [PW-1:0]           pick_idx;
  logic [REQ_W-1:0]        pick_req;
  logic [NUM_PORTS-1:0]    rotated;
  logic [NUM_PORTS-1:0]    winner_onehot;
  logic                    winner_ready;

`ifdef ARB_SNOOP_INVALIDATE_EN
  logic [NUM_PORTS-1:0]    snoop_inv_q;
  logic [ADDR_WIDTH-1:0]   snoop_addr_q;
`endif

  function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] base, input int unsigned offs);
    logic [PW:0] sum;
    sum = {1'b0, base} + (PW+1)'(offs);
    if (sum >= (PW+1)'(NUM_PORTS)) sum = sum - (PW+1)'(NUM_PORTS);
    return sum[PW-1:0];
  endfunction

  // Rotate the request vector so bit 0 is the port at the rr pointer.
  always_comb begin
    // NOTE: every variable assigned here gets a default first, so no path leaves it unassigned and no latch is inferred.
    pick_found = 1'b0;
    pick_idx   = '0;
    pick_req   = '0;
    rotated    = NUM_PORTS'({cache_request_ready, cache_request_ready} >> rr_q);
    for (int j = 0; j < NUM_PORTS; j++) begin
      if (!pick_found && rotated[j]) begin
        pick_found = 1'b1;
        pick_idx   = wrap_add(rr_q, j);
      end
    end
    for (int k = 0; k < NUM_PORTS; k++) begin
      if (pick_idx == PW'(k)) pick_req = cache_request[k*REQ_W +: REQ_W];
    end
  end

  assign rr_d          = wrap_add(winner_q, 1);
  assign winner_onehot = NUM_PORTS'(1) << winner_q;
  assign winner_ready  = cache_request_ready[winner_q];

  always_ff @(posedge clock or negedge reset) begin
    // NOTE: state updates use non-blocking assignments so every register samples pre-edge values.
    if (!reset) begin
      // NOTE: the captured request and line are plain registers, not a memory array, so they are reset with the rest.
      state_q      <= S_IDLE;
      rr_q         <= '0;
      winner_q     <= '0;
      grant_q      <= '0;
      latched_q    <= 1'b0;
      withdrawn_q  <= 1'b0;
      mem_valid_q  <= 1'b0;
      req_q        <= '0;
      line_q       <= '0;
      resp_valid_q <= '0;
`ifdef ARB_SNOOP_INVALIDATE_EN
      snoop_inv_q  <= '0;
      snoop_addr_q <= '0;
`endif
    end else begin
`ifdef ARB_SNOOP_INVALIDATE_EN
      snoop_inv_q <= '0;
`endif
      unique case (state_q)
        S_IDLE: begin
          // Winner is latched on one edge and presented to memory on the next.
          if (latched_q) begin
            latched_q   <= 1'b0;
            withdrawn_q <= 1'b0;
            mem_valid_q <= 1'b1;
            grant_q     <= winner_q;
            state_q     <= S_WAIT;
          end else if (pick_found) begin
            latched_q <= 1'b1;
            winner_q  <= pick_idx;
            req_q     <= pick_req;
          end
        end
        S_WAIT: begin
          if (!winner_ready) withdrawn_q <= 1'b1;
          if (memory_response_ready) begin
            line_q      <= memory_response;
            mem_valid_q <= 1'b0;
            state_q     <= S_RETURN;
            // A requester that let go during the transaction never sees the line.
            if (winner_ready && !withdrawn_q) resp_valid_q <= winner_onehot;
`ifdef ARB_SNOOP_INVALIDATE_EN
            if (req_q[REQ_W-1]) begin
              snoop_inv_q  <= ~winner_onehot;
              snoop_addr_q <= req_q[ADDR_WIDTH-1:0];
            end
`endif
          end
        end
        S_RETURN: begin
          if (!winner_ready && !memory_response_ready) begin
            resp_valid_q <= '0;
            rr_q         <= rr_d;
            state_q      <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign memory_request       = mem_valid_q ? req_q : '0;
  assign memory_request_ready = mem_valid_q;
  assign grant_port           = grant_q;
  assign cache_response_ready = resp_valid_q;

  always_comb begin
    cache_response = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      if (resp_valid_q[k]) cache_response[k*LINE_WIDTH +: LINE_WIDTH] = line_q;
    end
  end

`ifdef ARB_SNOOP_INVALIDATE_EN
  assign snoop_invalidate = snoop_inv_q;
  assign snoop_address    = snoop_addr_q;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a 2-port and a 4-port instance driven on falling edges.
`timescale 1ns/1ps
module tb_mem_port_arbiter;
  localparam int AW = 16;
  localparam int DW = 8;
  localparam int LW = 16;
  localparam int RW = 1 + DW + AW;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;

  logic [2*RW-1:0] c2_req;
  logic [1:0]      c2_rdy;
  logic [2*LW-1:0] c2_resp;
  logic [1:0]      c2_resp_rdy;
  logic [RW-1:0]   m2_req;
  logic            m2_req_rdy;
  logic [LW-1:0]   m2_resp;
  logic            m2_resp_rdy;
  logic [0:0]      g2;

  logic [4*RW-1:0] c4_req;
  logic [3:0]      c4_rdy;
  logic [4*LW-1:0] c4_resp;
  logic [3:0]      c4_resp_rdy;
  logic [RW-1:0]   m4_req;
  logic            m4_req_rdy;
  logic [LW-1:0]   m4_resp;
  logic            m4_resp_rdy;
  logic [1:0]      g4;

`ifdef ARB_SNOOP_INVALIDATE_EN
  logic [1:0]      s2_inv;
  logic [AW-1:0]   s2_addr;
  logic [3:0]      s4_inv;
  logic [AW-1:0]   s4_addr;
`endif

  mem_port_arbiter #(.NUM_PORTS(2)) dut2 (
    .clock(clk), .reset(rst_n),
    .cache_request(c2_req), .cache_request_ready(c2_rdy),
    .cache_response(c2_resp), .cache_response_ready(c2_resp_rdy),
    .memory_request(m2_req), .memory_request_ready(m2_req_rdy),
    .memory_response(m2_resp), .memory_response_ready(m2_resp_rdy),
    .grant_port(g2)
`ifdef ARB_SNOOP_INVALIDATE_EN
    , .snoop_invalidate(s2_inv), .snoop_address(s2_addr)
`endif
  );

  mem_port_arbiter #(.NUM_PORTS(4)) dut4 (
    .clock(clk), .reset(rst_n),
    .cache_request(c4_req), .cache_request_ready(c4_rdy),
    .cache_response(c4_resp), .cache_response_ready(c4_resp_rdy),
    .memory_request(m4_req), .memory_request_ready(m4_req_rdy),
    .memory_response(m4_resp), .memory_response_ready(m4_resp_rdy),
    .grant_port(g4)
`ifdef ARB_SNOOP_INVALIDATE_EN
    , .snoop_invalidate(s4_inv), .snoop_address(s4_addr)
`endif
  );

  function automatic logic [RW-1:0] mkreq(input logic rw, input logic [7:0] d, input logic [15:0] a);
    return {rw, d, a};
  endfunction

  task automatic step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    c2_req = '0; c2_rdy = '0; m2_resp = '0; m2_resp_rdy = 1'b0;
    c4_req = '0; c4_rdy = '0; m4_resp = '0; m4_resp_rdy = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic wait_grant2(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      step();
      ok = m2_req_rdy;
    end
  endtask

  task automatic wait_grant4(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      step();
      ok = m4_req_rdy;
    end
  endtask

  task automatic test_reset();
    do_reset();
    tests_run++; if (m2_req_rdy !== 1'b0) begin tests_failed++; $display("FAIL reset_mreq_rdy: got %0b want 0", m2_req_rdy); end
    tests_run++; if (m2_req !== '0) begin tests_failed++; $display("FAIL reset_mreq: got %h want 0", m2_req); end
    tests_run++; if (c2_resp_rdy !== 2'b00 || c2_resp !== '0) begin tests_failed++; $display("FAIL reset_resp: got rdy %b data %h want 0", c2_resp_rdy, c2_resp); end
    tests_run++; if (g2 !== 1'b0 || g4 !== 2'd0 || m4_req_rdy !== 1'b0) begin tests_failed++; $display("FAIL reset_grant: got g2 %0d g4 %0d m4rdy %0b want 0", g2, g4, m4_req_rdy); end
  endtask

  task automatic test_single_read();
    c2_req[0 +: RW] = mkreq(1'b0, 8'd0, 16'd23);
    c2_rdy = 2'b01;
    step();
    tests_run++; if (m2_req_rdy !== 1'b0) begin tests_failed++; $display("FAIL read_latency_early: got %0b want 0", m2_req_rdy); end
    step();
    tests_run++; if (m2_req_rdy !== 1'b1) begin tests_failed++; $display("FAIL read_latency: got %0b want 1", m2_req_rdy); end
    tests_run++; if (m2_req !== {1'b0, 8'd0, 16'd23} || g2 !== 1'b0) begin tests_failed++; $display("FAIL read_request: got %h grant %0d want %h grant 0", m2_req, g2, {1'b0, 8'd0, 16'd23}); end
    m2_resp = 16'h1000; m2_resp_rdy = 1'b1;
    step();
    tests_run++; if (c2_resp_rdy !== 2'b01) begin tests_failed++; $display("FAIL read_resp_rdy: got %b want 01", c2_resp_rdy); end
    tests_run++; if (c2_resp !== 32'h0000_1000) begin tests_failed++; $display("FAIL read_resp_data: got %h want 00001000", c2_resp); end
    tests_run++; if (m2_req_rdy !== 1'b0) begin tests_failed++; $display("FAIL read_mreq_drop: got %0b want 0", m2_req_rdy); end
    m2_resp_rdy = 1'b0; c2_rdy = 2'b00;
    step();
    tests_run++; if (c2_resp_rdy !== 2'b00) begin tests_failed++; $display("FAIL read_resp_drop: got %b want 00", c2_resp_rdy); end
  endtask

  task automatic test_simultaneous_writes();
    bit ok;
    do_reset();
    c2_req = {mkreq(1'b1, 8'd25, 16'd23), mkreq(1'b1, 8'd16, 16'd23)};
    c2_rdy = 2'b11;
    wait_grant2(ok);
    tests_run++; if (!ok || g2 !== 1'b0) begin tests_failed++; $display("FAIL sim_first_grant: got ok %0b grant %0d want grant 0", ok, g2); end
    tests_run++; if (m2_req !== {1'b1, 8'd16, 16'd23}) begin tests_failed++; $display("FAIL sim_first_req: got %h want %h", m2_req, {1'b1, 8'd16, 16'd23}); end
    m2_resp = 16'h00AA; m2_resp_rdy = 1'b1;
    step();
    tests_run++; if (c2_resp_rdy !== 2'b01 || c2_resp !== 32'h0000_00AA) begin tests_failed++; $display("FAIL sim_first_resp: got rdy %b data %h want 01 000000aa", c2_resp_rdy, c2_resp); end
    m2_resp_rdy = 1'b0; c2_rdy[0] = 1'b0;
    wait_grant2(ok);
    tests_run++; if (!ok || g2 !== 1'b1) begin tests_failed++; $display("FAIL sim_second_grant: got ok %0b grant %0d want grant 1", ok, g2); end
    tests_run++; if (m2_req !== {1'b1, 8'd25, 16'd23}) begin tests_failed++; $display("FAIL sim_second_req: got %h want %h", m2_req, {1'b1, 8'd25, 16'd23}); end
    m2_resp = 16'h00BB; m2_resp_rdy = 1'b1;
    step();
    tests_run++; if (c2_resp_rdy !== 2'b10 || c2_resp !== 32'h00BB_0000) begin tests_failed++; $display("FAIL sim_second_resp: got rdy %b data %h want 10 00bb0000", c2_resp_rdy, c2_resp); end
    m2_resp_rdy = 1'b0; c2_rdy = 2'b00;
    step();
    c2_rdy = 2'b11;
    wait_grant2(ok);
    tests_run++; if (!ok || g2 !== 1'b0) begin tests_failed++; $display("FAIL sim_rr_wrap: got ok %0b grant %0d want grant 0", ok, g2); end
    m2_resp_rdy = 1'b1;
    step();
    m2_resp_rdy = 1'b0; c2_rdy = 2'b00;
    step();
  endtask

  task automatic test_round_robin_4();
    bit ok;
    for (int k = 0; k < 4; k++) c4_req[k*RW +: RW] = mkreq(1'b0, 8'(k), 16'(100 + k));
    c4_rdy = 4'hF;
    for (int i = 0; i < 8; i++) begin
      wait_grant4(ok);
      tests_run++; if (!ok || g4 !== 2'(i % 4) || m4_req[15:0] !== 16'(100 + i % 4)) begin tests_failed++; $display("FAIL rr4_grant[%0d]: got ok %0b grant %0d addr %0d want grant %0d addr %0d", i, ok, g4, m4_req[15:0], i % 4, 100 + i % 4); end
      m4_resp = 16'(16'h4000 + i); m4_resp_rdy = 1'b1;
      step();
      tests_run++; if (c4_resp_rdy !== (4'b0001 << (i % 4))) begin tests_failed++; $display("FAIL rr4_resp[%0d]: got %b want %b", i, c4_resp_rdy, 4'b0001 << (i % 4)); end
      m4_resp_rdy = 1'b0; c4_rdy[i % 4] = 1'b0;
      step();
      c4_rdy[i % 4] = 1'b1;
    end
    c4_rdy = 4'h0;
    step();
  endtask

  task automatic test_withdraw();
    bit ok;
    bit pulse_seen;
    c2_req = {mkreq(1'b0, 8'd0, 16'd50), mkreq(1'b0, 8'd0, 16'd60)};
    c2_rdy = 2'b10;
    wait_grant2(ok);
    tests_run++; if (!ok || g2 !== 1'b1) begin tests_failed++; $display("FAIL wd_grant: got ok %0b grant %0d want grant 1", ok, g2); end
    c2_rdy = 2'b00;
    pulse_seen = 1'b0;
    repeat (4) begin
      step();
      if (c2_resp_rdy !== 2'b00) pulse_seen = 1'b1;
    end
    m2_resp = 16'h5555; m2_resp_rdy = 1'b1;
    step();
    if (c2_resp_rdy !== 2'b00) pulse_seen = 1'b1;
    tests_run++; if (m2_req_rdy !== 1'b0) begin tests_failed++; $display("FAIL wd_mem_done: got %0b want 0", m2_req_rdy); end
    m2_resp_rdy = 1'b0;
    step();
    if (c2_resp_rdy !== 2'b00) pulse_seen = 1'b1;
    tests_run++; if (pulse_seen !== 1'b0) begin tests_failed++; $display("FAIL wd_no_pulse: got pulse %0b want 0", pulse_seen); end
    c2_rdy = 2'b11;
    wait_grant2(ok);
    tests_run++; if (!ok || g2 !== 1'b0) begin tests_failed++; $display("FAIL wd_next_grant: got ok %0b grant %0d want grant 0", ok, g2); end
    m2_resp = 16'h6666; m2_resp_rdy = 1'b1;
    step();
    tests_run++; if (c2_resp_rdy !== 2'b01 || c2_resp !== 32'h0000_6666) begin tests_failed++; $display("FAIL wd_next_resp: got rdy %b data %h want 01 00006666", c2_resp_rdy, c2_resp); end
    m2_resp_rdy = 1'b0; c2_rdy = 2'b00;
    step();
  endtask

  task automatic test_reset_mid();
    bit ok;
    c2_req[0 +: RW] = mkreq(1'b1, 8'h77, 16'h0300);
    c2_rdy = 2'b01;
    wait_grant2(ok);
    tests_run++; if (!ok) begin tests_failed++; $display("FAIL rst_mid_grant: got %0b want 1", ok); end
    #2 rst_n = 1'b0;
    #1;
    tests_run++; if (m2_req_rdy !== 1'b0 || m2_req !== '0) begin tests_failed++; $display("FAIL rst_mid_async: got rdy %0b req %h want 0", m2_req_rdy, m2_req); end
    c2_rdy = 2'b00;
    step();
    step();
    rst_n = 1'b1;
    m2_resp = 16'hBEEF; m2_resp_rdy = 1'b1;
    c2_req = {mkreq(1'b0, 8'd0, 16'd2), mkreq(1'b0, 8'd0, 16'd1)};
    c2_rdy = 2'b11;
    step();
    tests_run++; if (m2_req_rdy !== 1'b0 || c2_resp_rdy !== 2'b00) begin tests_failed++; $display("FAIL rst_mid_idle: got mrdy %0b resp %b want 0 00", m2_req_rdy, c2_resp_rdy); end
    step();
    tests_run++; if (m2_req_rdy !== 1'b1 || g2 !== 1'b0) begin tests_failed++; $display("FAIL rst_mid_rr0: got mrdy %0b grant %0d want 1 0", m2_req_rdy, g2); end
    step();
    tests_run++; if (c2_resp_rdy !== 2'b01 || c2_resp[15:0] !== 16'hBEEF) begin tests_failed++; $display("FAIL early_resp_accept: got rdy %b data %h want 01 beef", c2_resp_rdy, c2_resp[15:0]); end
    m2_resp_rdy = 1'b0; c2_rdy = 2'b00;
    step();
  endtask

`ifdef ARB_SNOOP_INVALIDATE_EN
  task automatic test_snoop();
    bit ok;
    c2_req[0 +: RW] = mkreq(1'b1, 8'd16, 16'd23);
    c2_rdy = 2'b01;
    wait_grant2(ok);
    tests_run++; if (!ok || s2_inv !== 2'b00) begin tests_failed++; $display("FAIL snoop_quiet: got ok %0b inv %b want 1 00", ok, s2_inv); end
    m2_resp = 16'h1234; m2_resp_rdy = 1'b1;
    step();
    tests_run++; if (s2_inv !== 2'b10 || s2_addr !== 16'd23) begin tests_failed++; $display("FAIL snoop_pulse: got inv %b addr %0d want 10 23", s2_inv, s2_addr); end
    m2_resp_rdy = 1'b0; c2_rdy = 2'b00;
    step();
    tests_run++; if (s2_inv !== 2'b00) begin tests_failed++; $display("FAIL snoop_one_cycle: got %b want 00", s2_inv); end
    c2_req[0 +: RW] = mkreq(1'b0, 8'd0, 16'd23);
    c2_rdy = 2'b01;
    wait_grant2(ok);
    m2_resp_rdy = 1'b1;
    step();
    tests_run++; if (!ok || s2_inv !== 2'b00) begin tests_failed++; $display("FAIL snoop_read: got ok %0b inv %b want 1 00", ok, s2_inv); end
    m2_resp_rdy = 1'b0; c2_rdy = 2'b00;
    step();
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_read();
    test_simultaneous_writes();
    test_round_robin_4();
    test_withdraw();
    test_reset_mid();
`ifdef ARB_SNOOP_INVALIDATE_EN
    test_snoop();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Parametrised N-port memory arbiter placed between the per-CPU cache controllers and the single shared backing-memory port. It generalises the fixed two-cache arrangement to NUM_PORTS caches. Each cache's miss/write-through request is granted round-robin and forwarded as one memory transaction. The returned line is routed back to the requester only.

Parameters:
NUM_PORTS, 2, number of cache-side request channels (2..8)
ADDR_WIDTH, 16, byte address width
DATA_WIDTH, 8, write data width
LINE_WIDTH, 16, memory response (line) width
- Derived: REQ_W = 1+DATA_WIDTH+ADDR_WIDTH (25 at defaults), format {rw, data, address}, rw=1 write; PW = clog2(NUM_PORTS).

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
cache_request  input  NUM_PORTS*REQ_W  per-port request, port k at bits [k*REQ_W +: REQ_W]
cache_request_ready  input  NUM_PORTS  per-port request valid, level-held until serviced
cache_response  output  NUM_PORTS*LINE_WIDTH  per-port returned line
cache_response_ready  output  NUM_PORTS  per-port response valid
memory_request  output  REQ_W  forwarded request
memory_request_ready  output  1  memory request valid
memory_response  input  LINE_WIDTH  line from memory
memory_response_ready  input  1  memory response valid
grant_port  output  PW  index of the port currently being serviced (debug)

Behaviour:
- Reset (reset=0, async): FSM=IDLE; rr pointer=0; all outputs 0; captured request and line registers 0.
- FSM states: IDLE, WAIT, RETURN.
- IDLE:
  - Scan cache_request_ready starting at rr pointer, wrapping modulo NUM_PORTS.
  - The first asserted port wins. Latch its request and index.
  - Next cycle: WAIT.
  - No requests pending: stay in IDLE.
- WAIT:
  - memory_request = latched request; memory_request_ready=1; grant_port = winner.
  - On the edge where memory_response_ready=1: capture memory_response, drop memory_request_ready, go to RETURN.
- RETURN:
  - cache_response[winner] = captured line; cache_response_ready[winner]=1. All other ports' response lanes read 0.
  - Exit when both cache_request_ready[winner]=0 and memory_response_ready=0 (full four-phase on both sides).
  - On exit: drop cache_response_ready, set rr pointer = (winner+1) mod NUM_PORTS, go to IDLE.
- Latency:
  - Request asserted before edge N: memory_request_ready high after edge N+1.
  - memory_response_ready sampled at edge M: cache_response_ready high after edge M.
  - Minimum turnaround between grants is 1 idle cycle.
- Fairness: a port held asserted is serviced within NUM_PORTS grants.
- Requester withdraws in WAIT: the memory transaction still completes; the response is discarded (cache_response_ready not raised); rr pointer advances.
- Simultaneous requests from all ports with rr=0: service order 0,1,...,N-1.
- memory_response_ready already high on entry to WAIT: accepted on the first WAIT edge.
- Reset asserted mid-transaction: all outputs 0 immediately; the transaction is abandoned.

Optional Feature:
ARB_SNOOP_INVALIDATE_EN:
- Defined: adds outputs snoop_invalidate (NUM_PORTS) and snoop_address (ADDR_WIDTH).
- On WAIT->RETURN for a write (rw=1), pulse snoop_invalidate for exactly one cycle on every port except the winner, with snoop_address = the latched address. Reads never pulse.
- Undefined: the ports do not exist; there is no coherence traffic.

Test Plan:
1. Reset, then port0 read addr 23; memory returns 16'h1000 -> memory_request = {0,8'd0,16'd23}; cache_response_ready[0]=1 with cache_response[0]=16'h1000; cache_response_ready[1]=0.
2. Port0 write 16 @23 and port1 write 25 @23 in the same cycle, rr=0 -> port0 forwarded first, then port1; rr ends at 0.
3. NUM_PORTS=4, all ports held, 8 grants -> grant_port sequence 0,1,2,3,0,1,2,3.
4. Port1 drops cache_request_ready during WAIT; memory responds after 5 cycles -> no cache_response_ready pulse; the next grant goes to port0.
5. Reset pulled low in WAIT -> memory_request_ready=0 with no clock edge; after release, FSM is in IDLE with rr=0.
6. ARB_SNOOP_INVALIDATE_EN, port0 write 16 @23 -> snoop_invalidate=2'b10 for one cycle, snoop_address=23; a following read raises no pulse.
